// File: rtl/mips_pkg.sv
// mips_pkg: opcode, ALU function and control-vector constants shared by the datapath core
package mips_pkg;
  localparam logic [31:0] RESET_PC_INIT = 32'h003F_FFFC;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] ALU_NONE = 6'h00;
  localparam logic [5:0] ALU_JR   = 6'h08;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_NOR  = 6'h27;
  localparam logic [5:0] ALU_SLT  = 6'h2A;
  localparam logic [5:0] ALU_SLTU = 6'h2B;
  localparam logic [5:0] ALU_BEQ  = 6'h38;
  localparam logic [5:0] ALU_BNE  = 6'h39;
  typedef struct packed {
    logic reg_dst;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
  } ctrl_t;
  localparam ctrl_t CTRL_NONE  = 6'b000000;
  localparam ctrl_t CTRL_RTYPE = 6'b100001;
  localparam ctrl_t CTRL_JR    = 6'b100000;
  localparam ctrl_t CTRL_IMM   = 6'b000011;
  localparam ctrl_t CTRL_LW    = 6'b011011;
  localparam ctrl_t CTRL_SW    = 6'b000110;
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit ALU producing result plus branch/jump flags from a MIPS function code
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  fn,
  output logic [31:0] result,
  output logic        branch,
  output logic        jump
);
  always_comb begin
    result = '0;
    branch = 1'b0;
    jump   = 1'b0;
    case (fn)
      ALU_ADD, ALU_ADDU: result = a + b;
      ALU_SUB, ALU_SUBU: result = a - b;
      ALU_AND:           result = a & b;
      ALU_OR:            result = a | b;
      ALU_XOR:           result = a ^ b;
      ALU_NOR:           result = ~(a | b);
      ALU_SLT:           result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:          result = {31'd0, a < b};
      ALU_BEQ:           branch = (a == b);
      ALU_BNE:           branch = (a != b);
      ALU_JR: begin
        jump   = 1'b1;
        result = a;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_pc_decode_alu.sv
// mips_pc_decode_alu: single-cycle MIPS core slice -- PC register, main decoder, imm/ALU-B select, ALU
module mips_pc_decode_alu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_INIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_result,
  output logic        branch,
  output logic        jump,
  output logic        halt
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm;
  ctrl_t       ctrl;
  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign imm      = {{16{instruction[15]}}, instruction[15:0]};
  assign halt     = (instruction == 32'h0);
  assign pc_plus4 = pc + 32'd4;
  // branch/jump are status only; the PC always steps unless halted
  always_ff @(posedge clock or negedge reset)
    if (!reset) pc <= RESET_PC;
    else if (!halt) pc <= pc_plus4;
  always_comb begin
    ctrl   = CTRL_NONE;
    alu_op = ALU_NONE;
    case (opcode)
      OP_RTYPE: begin
        ctrl   = (funct == ALU_JR) ? CTRL_JR : CTRL_RTYPE;
        alu_op = funct;
      end
      OP_ADDI:  begin ctrl = CTRL_IMM; alu_op = ALU_ADD;  end
      OP_ADDIU: begin ctrl = CTRL_IMM; alu_op = ALU_ADDU; end
      OP_ANDI:  begin ctrl = CTRL_IMM; alu_op = ALU_AND;  end
      OP_ORI:   begin ctrl = CTRL_IMM; alu_op = ALU_OR;   end
      OP_XORI:  begin ctrl = CTRL_IMM; alu_op = ALU_XOR;  end
      OP_SLTI:  begin ctrl = CTRL_IMM; alu_op = ALU_SLT;  end
      OP_SLTIU: begin ctrl = CTRL_IMM; alu_op = ALU_SLTU; end
      OP_LW:    begin ctrl = CTRL_LW;  alu_op = ALU_ADDU; end
      OP_SW:    begin ctrl = CTRL_SW;  alu_op = ALU_ADDU; end
      OP_BEQ:   alu_op = ALU_BEQ;
      OP_BNE:   alu_op = ALU_BNE;
      OP_J:     alu_op = ALU_JR;
      default: ;
    endcase
  end
  assign reg_dst    = ctrl.reg_dst;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign mem_write  = ctrl.mem_write;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;
  mips_alu u_alu (
    .a      (rs_data),
    .b      (alu_src ? imm : rt_data),
    .fn     (alu_op),
    .result (alu_result),
    .branch (branch),
    .jump   (jump)
  );
endmodule

// File: tb/tb_mips_pc_decode_alu.sv
// tb_mips_pc_decode_alu: directed vector table plus PC reset/halt sequences
module tb_mips_pc_decode_alu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'h0022_1820;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] pc, pc_plus4, alu_result;
  logic        reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [5:0]  alu_op;
  logic        branch, jump, halt;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc;
  localparam logic [31:0] RPC = 32'h003F_FFFC;

  mips_pc_decode_alu dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .rs_data(rs_data), .rt_data(rt_data), .pc(pc), .pc_plus4(pc_plus4),
    .reg_dst(reg_dst), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .alu_op(alu_op), .alu_result(alu_result), .branch(branch),
    .jump(jump), .halt(halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  ctrl;
    logic [5:0]  op;
    logic [31:0] res;
    logic        br;
    logic        jp;
  } vec_t;
  vec_t v[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step_pc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    v[0]  = '{32'h0022_1820, 32'd7,         32'hFFFF_FFFF, 6'b100001, 6'h20, 32'd6,         1'b0, 1'b0};
    v[1]  = '{32'h0022_182A, 32'hFFFF_FFFF, 32'd1,         6'b100001, 6'h2A, 32'd1,         1'b0, 1'b0};
    v[2]  = '{32'h0022_182B, 32'hFFFF_FFFF, 32'd1,         6'b100001, 6'h2B, 32'd0,         1'b0, 1'b0};
    v[3]  = '{32'h8C22_0010, 32'h100,       32'hDEAD,      6'b011011, 6'h21, 32'h110,       1'b0, 1'b0};
    v[4]  = '{32'hAC22_FFFC, 32'h100,       32'hDEAD,      6'b000110, 6'h21, 32'hFC,        1'b0, 1'b0};
    v[5]  = '{32'h1022_0003, 32'd5,         32'd5,         6'b000000, 6'h38, 32'd0,         1'b1, 1'b0};
    v[6]  = '{32'h1022_0003, 32'd5,         32'd6,         6'b000000, 6'h38, 32'd0,         1'b0, 1'b0};
    v[7]  = '{32'h1422_0003, 32'd5,         32'd6,         6'b000000, 6'h39, 32'd0,         1'b1, 1'b0};
    v[8]  = '{32'h0020_0008, 32'h0040_0020, 32'd3,         6'b100000, 6'h08, 32'h0040_0020, 1'b0, 1'b1};
    v[9]  = '{32'hFC00_0000, 32'd9,         32'd9,         6'b000000, 6'h00, 32'd0,         1'b0, 1'b0};
    v[10] = '{32'h2022_0005, 32'd10,        32'd99,        6'b000011, 6'h20, 32'd15,        1'b0, 1'b0};
    v[11] = '{32'h3022_FFFF, 32'h1234,      32'd0,         6'b000011, 6'h24, 32'h1234,      1'b0, 1'b0};
    v[12] = '{32'h3422_8000, 32'd1,         32'd0,         6'b000011, 6'h25, 32'hFFFF_8001, 1'b0, 1'b0};
    v[13] = '{32'h3822_0F0F, 32'hFF,        32'd0,         6'b000011, 6'h26, 32'h0FF0,      1'b0, 1'b0};
    v[14] = '{32'h2822_FFFF, 32'hFFFF_FFFE, 32'd0,         6'b000011, 6'h2A, 32'd1,         1'b0, 1'b0};
    v[15] = '{32'h2C22_0001, 32'd0,         32'd0,         6'b000011, 6'h2B, 32'd1,         1'b0, 1'b0};
    v[16] = '{32'h0800_0010, 32'h1234,      32'd0,         6'b000000, 6'h08, 32'h1234,      1'b0, 1'b1};
    v[17] = '{32'h0022_1822, 32'd5,         32'd7,         6'b100001, 6'h22, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[18] = '{32'h0022_1827, 32'd0,         32'hF0F0_F0F0, 6'b100001, 6'h27, 32'h0F0F_0F0F, 1'b0, 1'b0};

    // reset held across clock edges, then released
    repeat (2) @(posedge clock);
    #1;
    chk("pc_in_reset", pc, RPC);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("pc_after_release", pc, RPC);
    chk("pc_plus4_after_release", pc_plus4, 32'h0040_0000);
    step_pc();
    step_pc();
    chk("pc_two_clocks", pc, 32'h0040_0004);
    exp_pc = 32'h0040_0004;

    foreach (v[i]) begin
      @(negedge clock);
      instruction = v[i].instr;
      rs_data     = v[i].rs;
      rt_data     = v[i].rt;
      #1;
      chk($sformatf("ctrl[%0d]", i),
          {reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write, halt},
          {v[i].ctrl, 1'b0});
      chk($sformatf("alu_op[%0d]", i), alu_op, v[i].op);
      chk($sformatf("result[%0d]", i), {branch, jump, alu_result}, {v[i].br, v[i].jp, v[i].res});
      step_pc();
      exp_pc = exp_pc + 32'd4;
      chk($sformatf("pc_step[%0d]", i), pc, exp_pc);
    end

    // halt freezes the PC
    @(negedge clock);
    instruction = 32'h0;
    #1;
    chk("halt_high", halt, 1'b1);
    repeat (3) step_pc();
    chk("pc_held_on_halt", pc, exp_pc);
    chk("pc_plus4_on_halt", pc_plus4, exp_pc + 32'd4);

    // async reset mid-cycle, no clock edge needed
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("pc_async_reset", pc, RPC);
    @(negedge clock);
    reset = 1'b1;
    instruction = 32'h0022_1820;
    #1;
    chk("pc_after_rerelease", pc, RPC);
    step_pc();
    chk("pc_resumes", pc, 32'h0040_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_pc_decode_alu.md
Name: mips_pc_decode_alu

Overview:
- Single-cycle MIPS datapath core: program-counter register with +4 incrementer, main decoder (controller), immediate sign-extend / ALU-B select, and 32-bit ALU with branch/jump flags.
- Sits between instruction ROM, register file and data memory. Those, the write-back mux and the write-register mux stay outside.
- Only the PC is sequential; everything else is combinational from `instruction`.

Parameters:
- RESET_PC, 32'h003FFFFC, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- instruction  in  32  current instruction fetched at `pc`.
- rs_data  in  32  register-file read data 1 (rs).
- rt_data  in  32  register-file read data 2 (rt).
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4.
- reg_dst  out  1  1 = write rd, 0 = write rt.
- mem_read  out  1  load.
- mem_to_reg  out  1  write-back from memory.
- mem_write  out  1  store.
- alu_src  out  1  1 = ALU B is sign-extended imm16.
- reg_write  out  1  register-file write enable.
- alu_op  out  6  ALU function code.
- alu_result  out  32  ALU result (memory address for lw/sw).
- branch  out  1  branch condition true.
- jump  out  1  jump instruction.
- halt  out  1  instruction == 32'h0.

Behaviour:
- PC register:
  - Async clear to RESET_PC while reset = 0.
  - Otherwise, on each rising clock edge: if halt, hold; else pc <= pc_plus4.
  - branch/jump do NOT redirect the PC; they are status outputs only.
- pc_plus4 = pc + 4, modulo 2^32.
- halt is combinational: high exactly when instruction == 0. A halted core stays halted until reset.
- Immediate = sign-extend of instruction[15:0] for all opcodes.
- ALU B = alu_src ? immediate : rt_data. ALU A = rs_data.
- Decoder, by opcode = instruction[31:26], funct = instruction[5:0]. Control vector is {reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write}.
  - 0x00 R-type: alu_op = funct; vector 1,0,0,0,0,1. Exception: funct 0x08 (jr) sets reg_write = 0.
  - 0x08 addi → 0x20; 0x09 addiu → 0x21; 0x0C andi → 0x24; 0x0D ori → 0x25; 0x0E xori → 0x26; 0x0A slti → 0x2A; 0x0B sltiu → 0x2B. Vector for all of these: 0,0,0,0,1,1.
  - 0x23 lw: alu_op 0x21; vector 0,1,1,0,1,1.
  - 0x2B sw: alu_op 0x21; vector 0,0,0,1,1,0.
  - 0x04 beq: alu_op 0x38; 0x05 bne: alu_op 0x39. All control bits 0.
  - 0x02 j: alu_op 0x08; all control bits 0.
  - Any other opcode: all control bits 0, alu_op 0x00.
- ALU by alu_op (combinational; branch = jump = 0 unless stated):
  - 0x20/0x21 add, 0x22/0x23 sub: wrap-around, no overflow trap.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu (unsigned): result is 32'h1 or 32'h0.
  - 0x38: branch = (A == B), result 0.
  - 0x39: branch = (A != B), result 0.
  - 0x08: jump = 1, result = A.
  - Any other code: result 0, branch = jump = 0.
- Reset mid-operation: PC returns to RESET_PC immediately. Combinational outputs simply follow the inputs.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI … OP_LW, OP_SW);
  - ALU function constants (ALU_ADD 0x20 … ALU_SLTU 0x2B, ALU_BEQ 0x38, ALU_BNE 0x39, ALU_JR 0x08);
  - RESET_PC default.
- One sub-module is natural: mips_alu (A, B, function → result, branch, jump).
- Decoder and PC logic stay in the top.

Test Plan:
- Reset: reset = 0, then release → pc = 32'h003FFFFC, pc_plus4 = 32'h00400000. After 2 clocks with non-zero instruction → pc = 32'h00400004.
- Halt: instruction = 0 → halt = 1 and pc holds across 3 clocks. Asserting reset then releasing → pc = RESET_PC.
- R-type add `0x00221820`, rs = 7, rt = 0xFFFFFFFF → alu_op 0x20, alu_result 6, reg_dst = 1, reg_write = 1. Same encoding with funct 0x2A, rs = −1, rt = 1 → result 1; funct 0x2B → result 0.
- lw `0x8C220010`, rs = 0x100 → alu_op 0x21, alu_result 0x110, mem_read = mem_to_reg = alu_src = reg_write = 1. sw `0xAC22FFFC`, rs = 0x100 → alu_result 0xFC, mem_write = 1, reg_write = 0.
- beq (opcode 0x04), rs = rt = 5 → branch = 1; rt = 6 → branch = 0. bne with rs = 5, rt = 6 → branch = 1. In all cases pc still advances by 4.
- jr (funct 0x08), rs = 0x00400020 → jump = 1, alu_result = 0x00400020, reg_write = 0. Unknown opcode 0x3F → all controls 0, alu_result 0.
